// File: rtl/tx_rdma_to_axis_eth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_rdma_to_axis_eth                                                      |
// | Turns one RDMA-encapsulated frame into the txc/txd stream pair of an     |
// | Ethernet MAC TX. Optional runt padding: define TX_RUNT_PAD_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tx_rdma_to_axis_eth #(
  parameter logic [3:0] TXC_FLAG        = 4'hA,
  parameter int         MIN_FRAME_BYTES = 60
) (
  input  logic        axis_clk,
  input  logic        axis_areset,
  input  logic        send_en,

  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,

  output logic [31:0] m_axis_txc_tdata,
  output logic [3:0]  m_axis_txc_tkeep,
  output logic        m_axis_txc_tvalid,
  input  logic        m_axis_txc_tready,
  output logic        m_axis_txc_tlast,

  output logic [31:0] m_axis_txd_tdata,
  output logic [3:0]  m_axis_txd_tkeep,
  output logic        m_axis_txd_tvalid,
  input  logic        m_axis_txd_tready,
  output logic        m_axis_txd_tlast,

  output logic        frame_sent,
  output logic [15:0] tx_len_bytes
);

  localparam logic [15:0] c_min_bytes = 16'(MIN_FRAME_BYTES);
  localparam logic [2:0]  c_txc_last  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TXC  = 2'd1,
    S_DATA = 2'd2
`ifdef TX_RUNT_PAD_EN
    ,S_PAD = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_txc_cnt;
  logic [15:0] r_byte_cnt;
  logic [31:0] r_txd_data;
  logic [3:0]  r_txd_keep;
  logic        r_txd_valid;
  logic        r_txd_last;
  logic        r_frame_sent;
  logic [15:0] r_tx_len;

  logic        w_txd_hs;
  logic        w_can_load;
  logic        w_accept;
  logic        w_done;
  logic        w_start;
  logic [2:0]  w_popcnt;
  logic [16:0] w_sum;
  logic [15:0] w_cnt_new;
  logic [31:0] w_ld_data;
  logic [3:0]  w_ld_keep;
  logic        w_ld_last;
  logic [15:0] w_ld_cnt;

  assign w_txd_hs   = r_txd_valid & m_axis_txd_tready;
  assign w_can_load = ~r_txd_valid | m_axis_txd_tready;
  // Once the final word sits in the register, input stays closed until it leaves.
  assign s_axis_tready = (r_state == S_DATA) & ~r_txd_last & w_can_load;
  assign w_accept   = s_axis_tvalid & s_axis_tready;
  assign w_done     = w_txd_hs & r_txd_last;
  assign w_start    = s_axis_tvalid & send_en;

  assign w_popcnt  = 3'(s_axis_tkeep[0]) + 3'(s_axis_tkeep[1])
                   + 3'(s_axis_tkeep[2]) + 3'(s_axis_tkeep[3]);
  assign w_sum     = {1'b0, r_byte_cnt} + {14'd0, w_popcnt};
  assign w_cnt_new = w_sum[16] ? 16'hFFFF : w_sum[15:0];

`ifdef TX_RUNT_PAD_EN
  logic [31:0] w_keep_mask;
  logic        w_pad_entry;
  logic [15:0] w_cnt_round;
  logic        w_round_short;
  logic [15:0] w_pad_cnt;
  logic        w_pad_last;

  assign w_keep_mask   = {{8{s_axis_tkeep[3]}}, {8{s_axis_tkeep[2]}},
                          {8{s_axis_tkeep[1]}}, {8{s_axis_tkeep[0]}}};
  assign w_pad_entry   = w_accept & s_axis_tlast & (w_cnt_new < c_min_bytes);
  // Only used for runts, so the round-up cannot wrap.
  assign w_cnt_round   = (w_cnt_new + 16'd3) & ~16'd3;
  assign w_round_short = w_cnt_round < c_min_bytes;
  assign w_pad_cnt     = r_byte_cnt + 16'd4;
  assign w_pad_last    = w_pad_cnt >= c_min_bytes;

  // A runt whose rounded length already reaches the minimum ends on this word.
  assign w_ld_data = w_pad_entry ? (s_axis_tdata & w_keep_mask) : s_axis_tdata;
  assign w_ld_keep = w_pad_entry ? 4'hF : s_axis_tkeep;
  assign w_ld_last = w_pad_entry ? ~w_round_short : s_axis_tlast;
  assign w_ld_cnt  = w_pad_entry ? w_cnt_round : w_cnt_new;
`else
  assign w_ld_data = s_axis_tdata;
  assign w_ld_keep = s_axis_tkeep;
  assign w_ld_last = s_axis_tlast;
  assign w_ld_cnt  = w_cnt_new;
`endif

  always_ff @(posedge axis_clk or posedge axis_areset) begin
    if (axis_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    m_axis_txc_tvalid = 1'b0;
    m_axis_txc_tdata  = 32'h0;
    m_axis_txc_tkeep  = 4'h0;
    m_axis_txc_tlast  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_TXC;
      end
      S_TXC: begin
        m_axis_txc_tvalid = 1'b1;
        m_axis_txc_tkeep  = 4'hF;
        m_axis_txc_tdata  = (r_txc_cnt == 3'd0) ? {TXC_FLAG, 28'h0} : 32'h0;
        m_axis_txc_tlast  = (r_txc_cnt == c_txc_last);
        if (m_axis_txc_tready && r_txc_cnt == c_txc_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_done) w_state_nxt = S_IDLE;
`ifdef TX_RUNT_PAD_EN
        else if (w_pad_entry && w_round_short) w_state_nxt = S_PAD;
`endif
      end
`ifdef TX_RUNT_PAD_EN
      S_PAD: begin
        if (w_done) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_areset) begin
    if (axis_areset) begin
      r_txc_cnt    <= 3'd0;
      r_byte_cnt   <= 16'd0;
      r_txd_data   <= 32'h0;
      r_txd_keep   <= 4'h0;
      r_txd_valid  <= 1'b0;
      r_txd_last   <= 1'b0;
      r_frame_sent <= 1'b0;
      r_tx_len     <= 16'd0;
    end else begin
      r_frame_sent <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_txc_cnt  <= 3'd0;
            r_byte_cnt <= 16'd0;
          end
        end
        S_TXC: begin
          if (m_axis_txc_tready && r_txc_cnt != c_txc_last) r_txc_cnt <= r_txc_cnt + 3'd1;
        end
        S_DATA: begin
          if (w_done) begin
            r_txd_valid  <= 1'b0;
            r_txd_last   <= 1'b0;
            r_frame_sent <= 1'b1;
            r_tx_len     <= r_byte_cnt;
          end else if (w_accept) begin
            r_txd_valid <= 1'b1;
            r_txd_data  <= w_ld_data;
            r_txd_keep  <= w_ld_keep;
            r_txd_last  <= w_ld_last;
            r_byte_cnt  <= w_ld_cnt;
          end else if (w_txd_hs) begin
            r_txd_valid <= 1'b0;
          end
        end
`ifdef TX_RUNT_PAD_EN
        S_PAD: begin
          if (w_done) begin
            r_txd_valid  <= 1'b0;
            r_txd_last   <= 1'b0;
            r_frame_sent <= 1'b1;
            r_tx_len     <= r_byte_cnt;
          end else if (w_can_load) begin
            r_txd_valid <= 1'b1;
            r_txd_data  <= 32'h0;
            r_txd_keep  <= 4'hF;
            r_txd_last  <= w_pad_last;
            r_byte_cnt  <= w_pad_cnt;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign m_axis_txd_tdata  = r_txd_data;
  assign m_axis_txd_tkeep  = r_txd_keep;
  assign m_axis_txd_tvalid = r_txd_valid;
  assign m_axis_txd_tlast  = r_txd_last;
  assign frame_sent        = r_frame_sent;
  assign tx_len_bytes      = r_tx_len;

endmodule
`default_nettype wire

// File: tb/tb_tx_rdma_to_axis_eth.sv
`timescale 1ns/1ps
`default_nettype none
// Directed-vector bench for tx_rdma_to_axis_eth: a frame table plus hand-written
// sequences for send_en gating and mid-frame reset.
module tb_tx_rdma_to_axis_eth;

`ifdef TX_RUNT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int MIN = 60;

  logic        axis_clk = 1'b0;
  logic        axis_areset;
  logic        send_en;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_txc_tdata;
  logic [3:0]  m_axis_txc_tkeep;
  logic        m_axis_txc_tvalid;
  logic        m_axis_txc_tready;
  logic        m_axis_txc_tlast;
  logic [31:0] m_axis_txd_tdata;
  logic [3:0]  m_axis_txd_tkeep;
  logic        m_axis_txd_tvalid;
  logic        m_axis_txd_tready;
  logic        m_axis_txd_tlast;
  logic        frame_sent;
  logic [15:0] tx_len_bytes;

  always #5 axis_clk = ~axis_clk;

  tx_rdma_to_axis_eth dut (
    .axis_clk          (axis_clk),
    .axis_areset       (axis_areset),
    .send_en           (send_en),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_txc_tdata  (m_axis_txc_tdata),
    .m_axis_txc_tkeep  (m_axis_txc_tkeep),
    .m_axis_txc_tvalid (m_axis_txc_tvalid),
    .m_axis_txc_tready (m_axis_txc_tready),
    .m_axis_txc_tlast  (m_axis_txc_tlast),
    .m_axis_txd_tdata  (m_axis_txd_tdata),
    .m_axis_txd_tkeep  (m_axis_txd_tkeep),
    .m_axis_txd_tvalid (m_axis_txd_tvalid),
    .m_axis_txd_tready (m_axis_txd_tready),
    .m_axis_txd_tlast  (m_axis_txd_tlast),
    .frame_sent        (frame_sent),
    .tx_len_bytes      (tx_len_bytes)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cur_frame   = -1;

  typedef struct {
    int         nwords;
    logic [3:0] last_keep;
    int         mode;       // 0: readies high, 1: txd tready toggles, 2: random readies
    int         exp_words;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (frame %0d): got 0x%08h expected 0x%08h", name, cur_frame, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int f, input int i);
    return 32'hC0DE0000 | 32'((f & 8'hFF) << 8) | 32'(i & 8'hFF);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_txc_tvalid"}, 32'(m_axis_txc_tvalid), 32'd0);
    chk({tag, "_txc_tdata"},  m_axis_txc_tdata,       32'd0);
    chk({tag, "_txd_tvalid"}, 32'(m_axis_txd_tvalid), 32'd0);
    chk({tag, "_txd_tdata"},  m_axis_txd_tdata,       32'd0);
    chk({tag, "_txd_tkeep"},  32'(m_axis_txd_tkeep),  32'd0);
    chk({tag, "_txd_tlast"},  32'(m_axis_txd_tlast),  32'd0);
    chk({tag, "_s_tready"},   32'(s_axis_tready),     32'd0);
    chk({tag, "_frame_sent"}, 32'(frame_sent),        32'd0);
    chk({tag, "_tx_len"},     32'(tx_len_bytes),      32'd0);
  endtask

  // Drives one frame and checks txc/txd against a small reference model.
  // abort_at >= 0 returns right after that many txd handshakes have been seen.
  task automatic run_frame(input int f, input int nwords, input logic [3:0] last_keep,
                           input int mode, input int exp_words, input int exp_len,
                           input int abort_at);
    logic [31:0] ed[$];
    logic [3:0]  ek[$];
    logic [31:0] d;
    logic [3:0]  k;
    logic [31:0] sd;
    logic [3:0]  sk;
    logic        sl;
    logic        prev_stall;
    logic        prev_final;
    int bytes, idx, ntxc, ntxd, nsent, cyc;
    cur_frame  = f;
    bytes      = 0;
    idx        = 0;
    ntxc       = 0;
    ntxd       = 0;
    nsent      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_final = 1'b0;
    sd = 32'h0; sk = 4'h0; sl = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      k = (i == nwords - 1) ? last_keep : 4'hF;
      d = pattern(f, i);
      bytes += $countones(k);
      if (i == nwords - 1 && PAD && bytes < MIN) begin
        for (int b = 0; b < 4; b++) if (!k[b]) d[8*b +: 8] = 8'h00;
        k = 4'hF;
        bytes = (bytes + 3) / 4 * 4;
      end
      ed.push_back(d);
      ek.push_back(k);
    end
    while (PAD && bytes < MIN) begin
      ed.push_back(32'h0);
      ek.push_back(4'hF);
      bytes += 4;
    end

    while (cyc < 3000) begin
      @(negedge axis_clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_tvalid", 32'(m_axis_txd_tvalid), 32'd1);
        chk("stall_tdata",  m_axis_txd_tdata,       sd);
        chk("stall_tkeep",  32'(m_axis_txd_tkeep),  32'(sk));
        chk("stall_tlast",  32'(m_axis_txd_tlast),  32'(sl));
      end
      if (frame_sent) begin
        nsent++;
        chk("frame_sent_after_last", 32'(prev_final), 32'd1);
        chk("tx_len_bytes", 32'(tx_len_bytes), 32'(exp_len));
        break;
      end
      m_axis_txd_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      m_axis_txc_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = (idx < nwords);
      s_axis_tdata  = pattern(f, idx);
      s_axis_tkeep  = (idx == nwords - 1) ? last_keep : 4'hF;
      s_axis_tlast  = (idx == nwords - 1);
      #1;
      if (m_axis_txc_tvalid) begin
        chk("txc_phase_txd_quiet", 32'(m_axis_txd_tvalid), 32'd0);
        chk("txc_phase_s_tready",  32'(s_axis_tready),     32'd0);
      end
      if (m_axis_txc_tvalid && m_axis_txc_tready) begin
        chk("txc_tdata", m_axis_txc_tdata, (ntxc == 0) ? 32'hA000_0000 : 32'h0);
        chk("txc_tkeep", 32'(m_axis_txc_tkeep), 32'hF);
        chk("txc_tlast", 32'(m_axis_txc_tlast), 32'(ntxc == 5));
        ntxc++;
      end
      prev_final = 1'b0;
      if (m_axis_txd_tvalid && m_axis_txd_tready) begin
        if (ntxd < ed.size()) begin
          chk("txd_tdata", m_axis_txd_tdata,       ed[ntxd]);
          chk("txd_tkeep", 32'(m_axis_txd_tkeep),  32'(ek[ntxd]));
          chk("txd_tlast", 32'(m_axis_txd_tlast),  32'(ntxd == ed.size() - 1));
        end else begin
          chk("txd_extra_word", 32'(ntxd), 32'(ed.size() - 1));
        end
        ntxd++;
        prev_final = m_axis_txd_tlast;
        if (abort_at >= 0 && ntxd == abort_at) return;
      end
      prev_stall = m_axis_txd_tvalid && !m_axis_txd_tready;
      sd = m_axis_txd_tdata;
      sk = m_axis_txd_tkeep;
      sl = m_axis_txd_tlast;
      if (s_axis_tvalid && s_axis_tready) idx++;
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout (frame %0d): got no frame_sent within 3000 cycles, required one", f);
    end
    s_axis_tvalid = 1'b0;
    chk("txc_words",        32'(ntxc),  32'd6);
    chk("txd_words",        32'(ntxd),  32'(exp_words));
    chk("input_consumed",   32'(idx),   32'(nwords));
    chk("frame_sent_count", 32'(nsent), 32'd1);
    @(negedge axis_clk);
    chk("frame_sent_pulse", 32'(frame_sent),    32'd0);
    chk("idle_s_tready",    32'(s_axis_tready), 32'd0);
  endtask

  initial begin
    axis_areset       = 1'b1;
    send_en           = 1'b1;
    s_axis_tdata      = 32'h0;
    s_axis_tkeep      = 4'h0;
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    m_axis_txc_tready = 1'b0;
    m_axis_txd_tready = 1'b0;

    vecs[0] = '{16, 4'hF, 0, 16, 64};
    vecs[1] = '{16, 4'hF, 1, 16, 64};
    vecs[2] = '{11, 4'h3, 0, PAD ? 15 : 11, PAD ? 60 : 42};
    vecs[3] = '{11, 4'h3, 1, PAD ? 15 : 11, PAD ? 60 : 42};
    vecs[4] = '{15, 4'h7, 1, 15,             PAD ? 60 : 59};
    vecs[5] = '{1,  4'h1, 2, PAD ? 15 : 1,   PAD ? 60 : 1};
    vecs[6] = '{20, 4'hF, 2, 20, 80};

    repeat (3) @(negedge axis_clk);
    #1;
    chk_quiet("reset");
    axis_areset = 1'b0;

    // send_en low holds off the frame; raising it starts TXC on the next edge.
    cur_frame     = 100;
    send_en       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pattern(7, 0);
    s_axis_tkeep  = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge axis_clk);
      #1;
      chk("gated_txc_tvalid", 32'(m_axis_txc_tvalid), 32'd0);
      chk("gated_txd_tvalid", 32'(m_axis_txd_tvalid), 32'd0);
      chk("gated_s_tready",   32'(s_axis_tready),     32'd0);
    end
    send_en = 1'b1;
    @(negedge axis_clk);
    #1;
    chk("start_txc_tvalid", 32'(m_axis_txc_tvalid), 32'd1);
    chk("start_txc_tdata",  m_axis_txc_tdata,       32'hA000_0000);
    run_frame(7, 16, 4'hF, 0, 16, 64, -1);

    for (int v = 0; v < 7; v++)
      run_frame(v, vecs[v].nwords, vecs[v].last_keep, vecs[v].mode,
                vecs[v].exp_words, vecs[v].exp_len, -1);

    // Reset lands while txd word 5 of 16 is being transferred.
    run_frame(9, 16, 4'hF, 0, 16, 64, 5);
    cur_frame   = 101;
    axis_areset = 1'b1;
    #1;
    chk_quiet("async_reset");
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    chk_quiet("reset_held");
    axis_areset = 1'b0;
    @(negedge axis_clk);
    chk_quiet("after_reset");
    run_frame(10, 16, 4'hF, 0, 16, 64, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
